// File: rtl/clic_trig_adapter.sv
// clic_trig_adapter
//   Per-source CLIC interrupt register file and trigger logic. Holds
//   clicintip / clicintie / clicintattr / clicintctl for N_SOURCE sources
//   behind one indexed write port and one registered read port. It
//   implements positive/negative edge and level triggers, and clears
//   vectored edge interrupts on an arbiter acknowledge.
//
//   Optional build macro: CLIC_IP_SYNC_EN. When it is defined, ip_i passes
//   through a two-flop synchronizer, which adds one cycle of input latency.
//   When it is undefined, ip_i is taken through a single sample flop.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   ip_i                   raw interrupt lines, one per source
//   wr_en_i/idx/be/data    indexed write: be b0 ip, b1 ie, b2 attr, b3 ctl
//   rd_en_i/rd_idx_i       read request; rd_valid_o/rd_data_o one cycle later
//   ack_valid_i/ack_id_i   arbiter acknowledge
//   intctl_o               effective clicintctl, 8 bits per source
//   shv_o, ie_o, ip_o      vectoring, enable and effective pending per source
//   trig_o                 2 bits per source: bit0 edge, bit1 negative polarity
module clic_trig_adapter #(
   parameter int N_SOURCE   = 256,
   parameter int INTCTLBITS = 8
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [N_SOURCE-1:0]              ip_i,
   input  logic                             wr_en_i,
   input  logic [$clog2(N_SOURCE)-1:0]      wr_idx_i,
   input  logic [3:0]                       wr_be_i,
   input  logic [31:0]                      wr_data_i,
   input  logic                             rd_en_i,
   input  logic [$clog2(N_SOURCE)-1:0]      rd_idx_i,
   output logic                             rd_valid_o,
   output logic [31:0]                      rd_data_o,
   input  logic                             ack_valid_i,
   input  logic [$clog2(N_SOURCE)-1:0]      ack_id_i,
   output logic [8*N_SOURCE-1:0]            intctl_o,
   output logic [N_SOURCE-1:0]              shv_o,
   output logic [N_SOURCE-1:0]              ie_o,
   output logic [N_SOURCE-1:0]              ip_o,
   output logic [2*N_SOURCE-1:0]            trig_o
);

   localparam int SRC_W = $clog2(N_SOURCE);
   // Unimplemented low bits of clicintctl read as 1. Keeping them in the
   // register as constant ones lets synthesis prune those flops.
   localparam logic [7:0] CTL_ONES = 8'((9'd1 << (8 - INTCTLBITS)) - 9'd1);

   // Composes the CLIC word: [7:0] ip, [15:8] ie, [23:16] attr, [31:24] ctl.
   // attr mode bits 23:22 read 2'b11 and reserved bits 21:19 read 0.
   function automatic logic [31:0] compose_word(input logic [7:0] ctl,
                                                input logic [1:0] trig,
                                                input logic       shv,
                                                input logic       ie,
                                                input logic       ip);
      compose_word = {ctl, 2'b11, 3'b000, trig, shv, 7'b0, ie, 7'b0, ip};
   endfunction

   logic [N_SOURCE-1:0]        ip_smp_p0;
   logic [N_SOURCE-1:0]        ip_prev_p1;
   logic [N_SOURCE-1:0]        ip_q, ip_d;
   logic [N_SOURCE-1:0]        ie_q, ie_d;
   logic [N_SOURCE-1:0]        shv_q, shv_d;
   logic [N_SOURCE-1:0][1:0]   trig_q, trig_d;
   logic [N_SOURCE-1:0][7:0]   ctl_q, ctl_d;
   logic [N_SOURCE-1:0]        wr_hit, ack_hit, edge_det;
   logic                       rd_in_range;
   logic [31:0]                rd_word;
   logic                       rd_vld_p1;
   logic [31:0]                rd_data_p1;

   // ---- input sample stage ----
`ifdef CLIC_IP_SYNC_EN
   logic [N_SOURCE-1:0] ip_sync_p0;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ip_sync_p0 <= '0;
         ip_smp_p0  <= '0;
      end else begin
         ip_sync_p0 <= ip_i;
         ip_smp_p0  <= ip_sync_p0;
      end
   end
`else
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ip_smp_p0 <= '0;
      else         ip_smp_p0 <= ip_i;
   end
`endif

   // ---- register next-state ----
   // Index comparisons only cover 0..N_SOURCE-1, so out-of-range writes and
   // acknowledges match no source. Trigger mode is taken from the post-write
   // value so a mode write is reflected in ip_o on the very next cycle.
   always_comb begin
      for (int i = 0; i < N_SOURCE; i++) begin
         wr_hit[i]   = wr_en_i && (wr_idx_i == SRC_W'(i));
         ack_hit[i]  = ack_valid_i && (ack_id_i == SRC_W'(i));
         ie_d[i]     = ie_q[i];
         shv_d[i]    = shv_q[i];
         trig_d[i]   = trig_q[i];
         ctl_d[i]    = ctl_q[i];
         if (wr_hit[i] && wr_be_i[1]) ie_d[i] = wr_data_i[8];
         if (wr_hit[i] && wr_be_i[2]) begin
            shv_d[i]  = wr_data_i[16];
            trig_d[i] = wr_data_i[18:17];
         end
         if (wr_hit[i] && wr_be_i[3]) ctl_d[i] = wr_data_i[31:24] | CTL_ONES;

         edge_det[i] = trig_d[i][1] ? (~ip_smp_p0[i] &  ip_prev_p1[i])
                                    : ( ip_smp_p0[i] & ~ip_prev_p1[i]);
         // Edge beats software write beats acknowledge, so no edge is lost.
         if (!trig_d[i][0])
            ip_d[i] = ip_smp_p0[i] ^ trig_d[i][1];
         else if (edge_det[i])
            ip_d[i] = 1'b1;
         else if (wr_hit[i] && wr_be_i[0])
            ip_d[i] = wr_data_i[0];
         else if (ack_hit[i] && shv_q[i])
            ip_d[i] = 1'b0;
         else
            ip_d[i] = ip_q[i];
      end
   end

   // Read composes the pre-write state, so a same-cycle write is not seen.
   always_comb begin
      rd_in_range = ({1'b0, rd_idx_i} < (SRC_W + 1)'(N_SOURCE));
      rd_word     = '0;
      if (rd_in_range)
         rd_word = compose_word(ctl_q[rd_idx_i], trig_q[rd_idx_i],
                                shv_q[rd_idx_i], ie_q[rd_idx_i], ip_q[rd_idx_i]);
   end

   // ---- register / edge-history / read-data stage ----
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ip_prev_p1 <= '0;
         ip_q       <= '0;
         ie_q       <= '0;
         shv_q      <= '0;
         trig_q     <= '0;
         ctl_q      <= {N_SOURCE{CTL_ONES}};
         rd_vld_p1  <= 1'b0;
         rd_data_p1 <= '0;
      end else begin
         ip_prev_p1 <= ip_smp_p0;
         ip_q       <= ip_d;
         ie_q       <= ie_d;
         shv_q      <= shv_d;
         trig_q     <= trig_d;
         ctl_q      <= ctl_d;
         rd_vld_p1  <= rd_en_i;
         if (rd_en_i) rd_data_p1 <= rd_word;
      end
   end

   assign rd_valid_o = rd_vld_p1;
   assign rd_data_o  = rd_data_p1;
   assign ip_o       = ip_q;
   assign ie_o       = ie_q;
   assign shv_o      = shv_q;
   assign trig_o     = trig_q;
   assign intctl_o   = ctl_q;

endmodule

// File: tb/tb_clic_trig_adapter.sv
// tb_clic_trig_adapter
//   Directed bench for clic_trig_adapter with N_SOURCE=12 (non-power-of-two,
//   so indices 12..15 are out of range) and INTCTLBITS=4.
module tb_clic_trig_adapter;

   localparam int N  = 12;
   localparam int SW = $clog2(N);

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    ip_i;
   logic            wr_en;
   logic [SW-1:0]   wr_idx;
   logic [3:0]      wr_be;
   logic [31:0]     wr_data;
   logic            rd_en;
   logic [SW-1:0]   rd_idx;
   logic            rd_valid;
   logic [31:0]     rd_data;
   logic            ack_valid;
   logic [SW-1:0]   ack_id;
   logic [8*N-1:0]  intctl;
   logic [N-1:0]    shv, ie, ip;
   logic [2*N-1:0]  trig;

   int total = 0;
   int bad   = 0;

   clic_trig_adapter #(.N_SOURCE(N), .INTCTLBITS(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .ip_i(ip_i),
      .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_be_i(wr_be), .wr_data_i(wr_data),
      .rd_en_i(rd_en), .rd_idx_i(rd_idx), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
      .ack_valid_i(ack_valid), .ack_id_i(ack_id),
      .intctl_o(intctl), .shv_o(shv), .ie_o(ie), .ip_o(ip), .trig_o(trig)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int idx, input logic [3:0] be, input logic [31:0] d);
      wr_en = 1'b1; wr_idx = SW'(idx); wr_be = be; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd(input int idx);
      rd_en = 1'b1; rd_idx = SW'(idx);
      tick();
      rd_en = 1'b0;
   endtask

   task automatic ack(input int idx);
      ack_valid = 1'b1; ack_id = SW'(idx);
      tick();
      ack_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; ip_i = '0; wr_en = 1'b0; wr_idx = '0; wr_be = '0; wr_data = '0;
      rd_en = 1'b0; rd_idx = '0; ack_valid = 1'b0; ack_id = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Reset state
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_ip", 32'(ip), 32'd0);
      rd(5);
      check("rst_rd5_valid", 32'(rd_valid), 32'd1);
      check("rst_rd5_data", rd_data, 32'h0FC0_0000);
      check("rst_intctl5", 32'(intctl[5*8 +: 8]), 32'h0F);
      tick();
      check("rd_valid_pulse", 32'(rd_valid), 32'd0);
      check("rd_data_hold", rd_data, 32'h0FC0_0000);

      // Source 3: shv=1, positive edge
      wr(3, 4'b0100, 32'h0003_0000);
      check("attr3_shv", 32'(shv[3]), 32'd1);
      check("attr3_trig", 32'(trig[7:6]), 32'd1);
      ip_i[3] = 1'b1; tick();
      ip_i[3] = 1'b0;
      check("edge_lat1", 32'(ip[3]), 32'd0);
      tick();
      check("edge_lat2", 32'(ip[3]), 32'd1);
      tick();
      check("edge_sticky", 32'(ip[3]), 32'd1);
      ack(3);
      check("ack_clear_shv1", 32'(ip[3]), 32'd0);

      // Source 3: shv=0, acknowledge leaves ip, software clears
      wr(3, 4'b0100, 32'h0002_0000);
      ip_i[3] = 1'b1; tick();
      ip_i[3] = 1'b0; tick();
      check("edge_shv0", 32'(ip[3]), 32'd1);
      ack(3);
      check("ack_noclr_shv0", 32'(ip[3]), 32'd1);
      wr(3, 4'b0001, 32'h0);
      check("sw_clear", 32'(ip[3]), 32'd0);

      // ie / ctl writes, composed read, read-before-write
      wr(3, 4'b0010, 32'h0000_0100);
      check("ie3_set", 32'(ie[3]), 32'd1);
      wr(3, 4'b1000, 32'hA500_0000);
      check("intctl3", 32'(intctl[3*8 +: 8]), 32'hAF);
      rd_en = 1'b1; rd_idx = SW'(3);
      wr(3, 4'b0010, 32'h0);
      rd_en = 1'b0;
      check("rd_prewrite", rd_data, 32'hAFC2_0100);
      check("ie3_clear", 32'(ie[3]), 32'd0);
      rd_en = 1'b1; rd_idx = SW'(5); tick();
      check("b2b_rd5", rd_data, 32'h0FC0_0000);
      rd_idx = SW'(3); tick();
      rd_en = 1'b0;
      check("b2b_rd3", rd_data, 32'hAFC2_0000);
      check("b2b_valid", 32'(rd_valid), 32'd1);

      // Source 7: negative level
      wr(7, 4'b0100, 32'h0004_0000);
      check("neglvl_low", 32'(ip[7]), 32'd1);
      ip_i[7] = 1'b1; tick();
      check("neglvl_lat1", 32'(ip[7]), 32'd1);
      tick();
      check("neglvl_high", 32'(ip[7]), 32'd0);
      wr(7, 4'b0001, 32'h1);
      check("neglvl_swwr", 32'(ip[7]), 32'd0);

      // Source 3: edge coincident with acknowledge, then trig flips while high
      wr(3, 4'b0100, 32'h0003_0000);
      ip_i[3] = 1'b1; tick();
      ip_i[3] = 1'b0; tick();
      check("edge2_set", 32'(ip[3]), 32'd1);
      ip_i[3] = 1'b1; tick();
      ack(3);
      check("edge_beats_ack", 32'(ip[3]), 32'd1);
      ack(3);
      check("ack_held_high", 32'(ip[3]), 32'd0);
      wr(3, 4'b0100, 32'h0007_0000);
      tick();
      check("flip_negedge", 32'(ip[3]), 32'd0);
      wr(3, 4'b0100, 32'h0003_0000);
      tick();
      check("flip_back", 32'(ip[3]), 32'd0);

      // Software write and acknowledge together: write wins
      wr_en = 1'b1; wr_idx = SW'(3); wr_be = 4'b0001; wr_data = 32'h1;
      ack(3);
      wr_en = 1'b0;
      check("wr_beats_ack", 32'(ip[3]), 32'd1);

      // Out-of-range index
      wr(13, 4'b1111, 32'hFFFF_FFFF);
      check("oor_wr_ie", 32'(ie), 32'h000);
      check("oor_wr_shv", 32'(shv), 32'h008);
      rd(13);
      check("oor_rd_valid", 32'(rd_valid), 32'd1);
      check("oor_rd_data", rd_data, 32'h0);
      ack(13);
      check("oor_ack", 32'(ip[3]), 32'd1);

      // Reset during a read
      rd_en = 1'b1; rd_idx = SW'(3);
      #3 rst_n = 1'b0;
      #1;
      check("rst_async_ctl", 32'(intctl[3*8 +: 8]), 32'h0F);
      tick();
      rd_en = 1'b0;
      check("rst_mid_valid", 32'(rd_valid), 32'd0);
      check("rst_mid_data", rd_data, 32'h0);
      check("rst_mid_shv", 32'(shv), 32'h0);
      rst_n = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
